// File: rtl/wave_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wave_pkg
// Brief    : Shared encodings and constants for the multi-channel DDS.
// Revision : 1.0
// ============================================================================
package wave_pkg;

    localparam int SINE_ADDR_W = 14;
    localparam int SINE_OUT_W  = 12;

    localparam logic [1:0] MODE_SINE   = 2'd0;
    localparam logic [1:0] MODE_SQUARE = 2'd1;
    localparam logic [1:0] MODE_SAW    = 2'd2;
    localparam logic [1:0] MODE_TRI    = 2'd3;

    localparam logic [1:0] CFG_STEP   = 2'd0;
    localparam logic [1:0] CFG_OFFSET = 2'd1;
    localparam logic [1:0] CFG_AMP    = 2'd2;
    localparam logic [1:0] CFG_MODE   = 2'd3;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } sweep_state_t;

endpackage
`default_nettype wire

// File: rtl/sinetable.sv
`default_nettype none
// ============================================================================
// Module   : sinetable
// Brief    : Combinational offset-binary sine, 14-bit phase in, 12-bit out.
// Revision : 1.0
// ============================================================================
module sinetable
    import wave_pkg::*;
(
    input  logic [SINE_ADDR_W-1:0] phase,
    output logic [SINE_OUT_W-1:0]  sine
);

    // Each half-wave is the parabola x*(N-x)/N, peaking at 2048 magnitude.
    logic [12:0] w_x;
    logic [13:0] w_rem;
    logic [24:0] w_prod;
    logic [11:0] w_mag;

    assign w_x    = phase[12:0];
    assign w_rem  = 14'd8192 - {1'b0, w_x};
    assign w_prod = {12'd0, w_x} * {11'd0, w_rem};
    assign w_mag  = 12'(w_prod >> 13);
    assign sine   = phase[13] ? (12'd2048 - w_mag) : (12'd2047 + w_mag);

endmodule
`default_nettype wire

// File: rtl/wave_shaper.sv
`default_nettype none
// ============================================================================
// Module   : wave_shaper
// Brief    : Combinational waveform select from phase / sine lookup.
// Revision : 1.0
// ============================================================================
module wave_shaper
    import wave_pkg::*;
(
    input  logic [12:0]           phase,
    input  logic [SINE_OUT_W-1:0] sine,
    input  logic [1:0]            mode,
    output logic [SINE_OUT_W-1:0] shape
);

    logic [11:0] w_tri;

    assign w_tri = phase[11:0];

    always_comb begin
        shape = sine;
        case (mode)
            MODE_SINE:   shape = sine;
            MODE_SQUARE: shape = phase[12] ? 12'd0 : 12'hFFF;
            MODE_SAW:    shape = phase[12:1];
            MODE_TRI:    shape = phase[12] ? ~w_tri : w_tri;
            default:     shape = sine;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/wave_dds_multi.sv
`default_nettype none
// ============================================================================
// Module   : wave_dds_multi
// Brief    : NUM_CH phase accumulators swept through one shared sinetable.
// Revision : 1.0
// ============================================================================
module wave_dds_multi
    import wave_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int PHASE_W = 16,
    parameter int AMP_W   = 12,
    parameter int OUT_W   = SINE_OUT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               sync,
    input  logic               cfg_we,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic [1:0]         cfg_addr,
    input  logic [PHASE_W-1:0] cfg_data,
    output logic               busy,
    output logic               out_valid,
    output logic [CH_W-1:0]    out_ch,
    output logic [OUT_W-1:0]   out_sample,
    output logic               overrun
);

    localparam logic [CH_W-1:0] C_LAST_CH = CH_W'(NUM_CH - 1);

    logic [PHASE_W-1:0] r_acc    [NUM_CH];
    logic [PHASE_W-1:0] r_step   [NUM_CH];
    logic [PHASE_W-1:0] r_offset [NUM_CH];
    logic [AMP_W-1:0]   r_amp    [NUM_CH];
    logic [1:0]         r_mode   [NUM_CH];

    sweep_state_t       r_state, w_state_next;
    logic [CH_W-1:0]    r_slot, w_slot_next;
    logic               w_start;
    logic               w_cfg_ch_ok;

    logic                    r_s1_valid;
    logic [CH_W-1:0]         r_s1_ch;
    logic [SINE_ADDR_W-1:0]  r_s1_addr;
    logic [1:0]              r_s1_mode;
    logic [AMP_W-1:0]        r_s1_amp;

    logic                    r_s2_valid;
    logic [CH_W-1:0]         r_s2_ch;
    logic [SINE_OUT_W-1:0]   r_s2_s;
    logic [AMP_W-1:0]        r_s2_amp;

    logic [PHASE_W-1:0]            w_sum;
    logic [SINE_ADDR_W-1:0]        w_addr;
    logic [SINE_OUT_W-1:0]         w_sine;
    logic [SINE_OUT_W-1:0]         w_shape;
    logic [SINE_OUT_W+AMP_W-1:0]   w_prod;

    assign busy    = (r_state == ST_SWEEP);
    assign w_start = tick && !busy;

    generate
        if (NUM_CH == (1 << CH_W)) begin : g_full_ch
            assign w_cfg_ch_ok = 1'b1;
        end else begin : g_part_ch
            assign w_cfg_ch_ok = (int'(cfg_ch) < NUM_CH);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_step[i]   <= '0;
                r_offset[i] <= '0;
                r_amp[i]    <= '0;
                r_mode[i]   <= '0;
            end
        end else if (cfg_we && w_cfg_ch_ok) begin
            case (cfg_addr)
                CFG_STEP:   r_step[cfg_ch]   <= cfg_data;
                CFG_OFFSET: r_offset[cfg_ch] <= cfg_data;
                CFG_AMP:    r_amp[cfg_ch]    <= cfg_data[AMP_W-1:0];
                CFG_MODE:   r_mode[cfg_ch]   <= cfg_data[1:0];
                default:    ;
            endcase
        end
    end

    // sync wins over a same-cycle advance; the sweep itself still starts.
    always_ff @(posedge clk) begin
        if (reset || sync) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_acc[i] <= '0;
            end
        end else if (w_start) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_acc[i] <= r_acc[i] + r_step[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_slot  <= '0;
            overrun <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_slot  <= w_slot_next;
            if (tick && busy) begin
                overrun <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_slot_next  = r_slot;
        case (r_state)
            ST_IDLE: begin
                if (tick) begin
                    w_state_next = ST_SWEEP;
                    w_slot_next  = '0;
                end
            end
            ST_SWEEP: begin
                if (r_slot == C_LAST_CH) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_slot_next = r_slot + CH_W'(1);
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_sum  = r_acc[r_slot] + r_offset[r_slot];
    assign w_addr = SINE_ADDR_W'(w_sum >> (PHASE_W - SINE_ADDR_W));

    sinetable u_sinetable (
        .phase (r_s1_addr),
        .sine  (w_sine)
    );

    wave_shaper u_wave_shaper (
        .phase (r_s1_addr[SINE_ADDR_W-1:1]),
        .sine  (w_sine),
        .mode  (r_s1_mode),
        .shape (w_shape)
    );

    assign w_prod = {{AMP_W{1'b0}}, r_s2_s} * {{SINE_OUT_W{1'b0}}, r_s2_amp};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_ch    <= '0;
            r_s1_addr  <= '0;
            r_s1_mode  <= '0;
            r_s1_amp   <= '0;
            r_s2_valid <= 1'b0;
            r_s2_ch    <= '0;
            r_s2_s     <= '0;
            r_s2_amp   <= '0;
            out_valid  <= 1'b0;
            out_ch     <= '0;
            out_sample <= '0;
        end else begin
            r_s1_valid <= busy;
            if (busy) begin
                r_s1_ch   <= r_slot;
                r_s1_addr <= w_addr;
                r_s1_mode <= r_mode[r_slot];
                r_s1_amp  <= r_amp[r_slot];
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_ch  <= r_s1_ch;
                r_s2_s   <= w_shape;
                r_s2_amp <= r_s1_amp;
            end
            out_valid <= r_s2_valid;
            // Sample and channel hold their last value between bursts.
            if (r_s2_valid) begin
                out_ch     <= r_s2_ch;
                out_sample <= OUT_W'(w_prod >> AMP_W);
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/wave_dds_multi.md
Name: wave_dds_multi

Overview:
- Multi-channel direct digital synthesis (DDS) generator.
- Holds NUM_CH independent phase accumulators, each with its own phase step, phase offset, amplitude and waveform mode (sine, square, triangle, saw).
- On each sample tick, all accumulators advance together. The channels are then evaluated one per cycle through a single shared sinetable, with amplitude scaling, and emitted as a tagged sample stream to the DAC/mixer stage.

Parameters:
- NUM_CH, 4, number of channels (≥1).
- CH_W, $clog2(NUM_CH) min 1, channel index width.
- PHASE_W, 16, accumulator/step/offset width (≥14).
- AMP_W, 12, amplitude width (≤PHASE_W).
- OUT_W, 12, sample width; fixed to sinetable result width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tick  in  1  sample strobe; starts one sweep of all channels
- sync  in  1  zero all accumulators (phase alignment)
- cfg_we  in  1  config write strobe
- cfg_ch  in  CH_W  target channel
- cfg_addr  in  2  0=phase step, 1=phase offset, 2=amplitude (low AMP_W bits), 3=mode (low 2 bits)
- cfg_data  in  PHASE_W  write data
- busy  out  1  sweep in progress
- out_valid  out  1  out_sample/out_ch valid this cycle
- out_ch  out  CH_W  channel of out_sample
- out_sample  out  OUT_W  scaled unsigned sample
- overrun  out  1  sticky: tick arrived while busy

Behaviour:
- One clock; reset is synchronous and active-high. When reset is high: accumulators, step, offset, amp and mode registers go to 0; busy=0, out_valid=0, out_ch=0, out_sample=0, overrun=0; the pipeline is flushed. Reset mid-sweep aborts the sweep and emits no further out_valid.
- Config:
  - A write is accepted in one cycle whenever cfg_we=1.
  - Writes with cfg_ch ≥ NUM_CH are ignored.
  - A write during a sweep affects only slots issued after the write cycle.
- Tick handling (cycle T):
  - If tick=1 and busy=0, every accumulator does acc <= acc + step, mod 2^PHASE_W. The step used is the register value before any same-cycle write.
  - busy=1 from T+1 to T+NUM_CH inclusive. The slot counter issues channel k at cycle T+1+k.
  - If tick=1 and busy=1, the tick is ignored and overrun is set until reset.
- sync:
  - sync=1 forces all accumulators to 0; it has priority over a same-cycle tick advance.
  - The sweep still starts and uses the zeroed phases.
- Per slot:
  - p = (acc + offset) mod 2^PHASE_W; the offset is applied at read, not loaded.
  - Stage 1: register p[PHASE_W-1 -: 14] as the address and register the mode.
  - Stage 2: register the shaped sample s (12-bit unsigned) and amp:
    - mode 0 (sine): s = sinetable result.
    - mode 1 (square): s = msb ? 0 : 4095.
    - mode 2 (saw): s = p top 12 bits.
    - mode 3 (triangle): t = p bits [PHASE_W-2 -: 12]; s = msb ? ~t : t.
  - Stage 3: out_sample = (s * amp) >> AMP_W. The full AMP_W+12 bit product is used, with no truncation before the shift; out_valid=1, out_ch=k.
- Latency: channel k appears with out_valid at T+4+k. Outputs arrive strictly in channel order, one per cycle, NUM_CH consecutive valid cycles per tick.
- Back-to-back: a tick at T+NUM_CH+1 or later is legal. The pipeline tail may overlap the next sweep head with no bubble.
- out_sample holds its last value when out_valid=0.

Decomposition:
- Package wave_pkg holds:
  - mode encodings MODE_SINE/SQUARE/SAW/TRI;
  - cfg_addr encodings CFG_STEP/OFFSET/AMP/MODE;
  - the SINE_ADDR_W=14 and SINE_OUT_W=12 constants.
- Instantiate the existing sinetable (14-bit phase in, 12-bit result out) once.
- One natural sub-module: wave_shaper (combinational mode mux from p/sine result to s), used between stages 1 and 2.

Test Plan:
- Reset, then ch0: step=0x0400, amp=4095, mode=saw. Tick at cycles 10, 20, 30 -> ch0 out_sample=0x03F, 0x07F, 0x0BF (s=0x040/0x080/0x0C0 scaled by 4095/4096); out_valid 4 cycles after each tick.
- NUM_CH=4, all modes square, amp=2048, offsets 0/0x8000/0/0x8000, step=0 -> on tick, out_ch 0,1,2,3 on consecutive cycles with samples 2047,0,2047,0.
- Step=0xFFFF, tick 2 times -> acc wraps to 0xFFFE; saw output=0xFFF·amp>>12. Then sync+tick in the same cycle -> phase 0, saw output 0.
- Tick asserted while busy -> ignored, overrun=1 and held; sweep count unchanged; reset clears overrun.
- Write amp on ch2 during a sweep at the ch1 issue cycle -> ch2 output this sweep uses the new amp; write to cfg_ch=5 (NUM_CH=4) -> no register change.
- Sine mode, amp=4095, offset=0x4000, step=0 -> out_sample equals sinetable(0x1000)*4095>>12; reset asserted mid-sweep -> no further out_valid, outputs 0.
